exe_stage_mc: RTL and testbench
===============================

Name: exe_stage_mc

Overview:
- Parametrised, multi-cycle execute stage for the ARM pipeline.
- Accepts one decoded instruction per valid/ready handshake and builds Val2 with an iterative shifter that moves STEP bits per cycle.
- Runs the ALU and computes the branch target, then holds a registered result until the memory stage accepts it.
- Successor to the single-cycle execute stage: generic width, configurable shifter throughput, and backpressure.

Parameters:
- WIDTH, 32, datapath width; must be 16 or more and a power of 2.
- STEP, 1, bit positions shifted per cycle in the SHIFT state; must be 1 to 16.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous reset, active-low; sampled on the rising edge of clk.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block can accept an instruction.
- mem_read, mem_write, imm  in  1 each  decoded control.
- exe_cmd  in  4  ALU command.
- sr_in  in  4  status register {N,Z,C,V}; carry-in is sr_in[1].
- pc  in  WIDTH  PC of the instruction.
- val_rn, val_rm  in  WIDTH  register operands.
- shift_op  in  12  shifter operand field.
- signed_imm_24  in  24  branch offset.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- alu_result, br_address  out  WIDTH  registered results.
- status  out  4  {N,Z,C,V} produced by the ALU.

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE; out_valid=0.
  - alu_result, br_address and status go to 0; in_ready=1 in the following cycle.
  - Reset mid-operation abandons any in-flight instruction.
- States: IDLE, SHIFT, EXEC, HOLD.
- IDLE:
  - in_ready=1. On in_valid, capture all inputs.
  - Load the shifter register with the initial value, kind and amount (below).
  - Next state is SHIFT if amount>0, otherwise EXEC.
- Val2 selection, in priority order:
  - mem_read|mem_write: zero-extended shift_op[11:0], amount 0.
  - imm: zero-extended shift_op[7:0], ROR by 2*shift_op[11:8].
  - Otherwise: val_rm, with kind from shift_op[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR) and amount shift_op[11:7].
  - If shift_op[4]=1 (register-specified shift, not supported), Val2 = val_rm unshifted, amount 0.
- SHIFT:
  - Each cycle shift by k = min(STEP, remaining) and decrement remaining by k.
  - Leave for EXEC when remaining reaches 0.
  - ASR replicates the sign bit; ROR wraps bit 0 into the MSB.
- EXEC (one cycle):
  - ALU computes val_rn op Val2.
  - br_address = pc + sign-extend(signed_imm_24) to WIDTH, with no shift of the offset.
  - Results are registered; out_valid=1; next state HOLD.
- HOLD:
  - Outputs stay stable while out_ready=0.
  - On out_ready=1: out_valid=0 next cycle, next state IDLE.
  - in_ready stays 0 in HOLD, so a new instruction is accepted no earlier than one cycle after the output handshake.
- in_ready=0 in SHIFT, EXEC and HOLD.
- Latency from the accepting edge to out_valid=1: 1 + ceil(amount/STEP) edges.
- ALU commands (from the package):
  - 0001 MOV = Val2; 1001 MVN = ~Val2.
  - 0010 ADD; 0011 ADC (+C).
  - 0100 SUB = Rn-Val2; 0101 SBC = Rn-Val2-!C.
  - 0110 AND; 0111 ORR; 1000 EOR.
  - Any other code: result 0, flags 0.
- Flags:
  - N = result MSB; Z = (result==0).
  - C = carry-out for add, NOT borrow for subtract, 0 for logical ops.
  - V = signed overflow for add/subtract, 0 otherwise.
  - All arithmetic is modulo 2^WIDTH.
- in_valid is ignored outside IDLE. Captured fields are unaffected by input changes after the capture edge.

Decomposition:
- Package exe_pkg holds:
  - exe_cmd encodings;
  - shift kind encodings (LSL/LSR/ASR/ROR);
  - the state enum;
  - flag bit indices.
- One sub-module, alu_flags: combinational WIDTH-parametrised ALU producing result and {N,Z,C,V}.
- The FSM and iterative shifter live in exe_stage_mc.

Test Plan:
- Reset: hold rst=0 for 2 cycles, with in_valid=1 during reset -> out_valid=0, alu_result=0, status=0; in_ready=1 on the first cycle after release.
- Immediate rotate, STEP=1:
  - Stimulus: imm=1, shift_op=0x1FF, val_rn=1, ADD.
  - Required: Val2=0xC000003F; out_valid 3 edges after accept; alu_result=0xC0000040; status=1000.
- Register ROR, STEP=4:
  - Stimulus: val_rm=0x0000000F, shift_op=0x260 (ROR 4), MOV.
  - Required: 1 shift cycle; alu_result=0xF0000000; N=1, Z=0.
- Memory offset:
  - Stimulus: mem_read=1, shift_op=0xFFF, val_rn=0x100, ADD, pc=0x100, signed_imm_24=0xFFFFFC.
  - Required: alu_result=0x10FF; br_address=0xFC; latency 1.
- Overflow: SUB with val_rn=0x80000000 and Val2=1 -> 0x7FFFFFFF; N=0, Z=0, C=1, V=1.
- Backpressure and reset mid-operation:
  - Hold out_ready=0 for 3 cycles -> outputs stable and in_ready=0; the next instruction is accepted 1 cycle after the handshake.
  - Assert rst=0 during SHIFT -> IDLE with out_valid never asserted.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU commands, shift kinds,
// FSM states and status flag bit positions.
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    typedef enum logic [1:0] {
        SH_LSL = 2'b00,
        SH_LSR = 2'b01,
        SH_ASR = 2'b10,
        SH_ROR = 2'b11
    } shift_kind_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_EXEC  = 2'b10,
        S_HOLD  = 2'b11
    } exe_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/exe_stage_mc_if.sv
// Instruction-in / result-out bus of the execute stage, plus the FSM state for observation.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid never waits on ready, and the payload is held stable while valid=1 and ready=0.
interface exe_stage_mc_if import exe_pkg::*; #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic             mem_read;
    logic             mem_write;
    logic             imm;
    logic [3:0]       exe_cmd;
    logic [3:0]       sr_in;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] val_rn;
    logic [WIDTH-1:0] val_rm;
    logic [11:0]      shift_op;
    logic [23:0]      signed_imm_24;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] br_address;
    logic [3:0]       status;
    exe_state_t       dbg_state;

    modport master (
        output in_valid, mem_read, mem_write, imm, exe_cmd, sr_in, pc, val_rn, val_rm,
               shift_op, signed_imm_24, out_ready,
        input  in_ready, out_valid, alu_result, br_address, status, dbg_state
    );

    modport slave (
        input  in_valid, mem_read, mem_write, imm, exe_cmd, sr_in, pc, val_rn, val_rm,
               shift_op, signed_imm_24, out_ready,
        output in_ready, out_valid, alu_result, br_address, status, dbg_state
    );
endinterface

// File: rtl/exe_stage_mc_alu_flags.sv
// Combinational ALU: result of a op b and the {N,Z,C,V} flags it produces.
module alu_flags import exe_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       cmd,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    logic [WIDTH:0] sum;
    logic           is_arith;
    logic           is_sub;
    logic           known;

    always_comb begin
        sum      = '0;
        result   = '0;
        flags    = '0;
        is_arith = 1'b0;
        is_sub   = 1'b0;
        known    = 1'b1;
        // Subtraction is a + ~b + 1 so the carry-out is directly NOT borrow.
        case (cmd)
            CMD_MOV: result = b;
            CMD_MVN: result = ~b;
            CMD_ADD: begin sum = {1'b0, a} + {1'b0, b}; is_arith = 1'b1; end
            CMD_ADC: begin sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin); is_arith = 1'b1; end
            CMD_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                is_arith = 1'b1; is_sub = 1'b1;
            end
            CMD_SBC: begin
                sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(cin);
                is_arith = 1'b1; is_sub = 1'b1;
            end
            CMD_AND: result = a & b;
            CMD_ORR: result = a | b;
            CMD_EOR: result = a ^ b;
            default: known = 1'b0;
        endcase
        if (is_arith) result = sum[WIDTH-1:0];
        if (known) begin
            flags[FLAG_N] = result[WIDTH-1];
            flags[FLAG_Z] = (result == '0);
            if (is_arith) begin
                flags[FLAG_C] = sum[WIDTH];
                flags[FLAG_V] = is_sub
                    ? ((a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]))
                    : ((a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]));
            end
        end
    end
endmodule

// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage: captures an instruction, shifts Val2 STEP bits per cycle,
// runs the ALU and branch adder, then holds the registered result until accepted.
module exe_stage_mc import exe_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic          clk,
    input  logic          rst,
    exe_stage_mc_if.slave bus
);
    localparam int         AW       = $clog2(WIDTH) + 1;
    localparam logic [4:0] STEP_AMT = 5'(STEP);

    exe_state_t       state_q;
    shift_kind_t      kind_q;
    logic [WIDTH-1:0] sh_q, rn_q, pc_q;
    logic [4:0]       rem_q;
    logic [23:0]      off_q;
    logic [3:0]       cmd_q;
    logic             cin_q;
    logic             out_valid_q, in_ready_q;
    logic [WIDTH-1:0] alu_result_q, br_q;
    logic [3:0]       status_q;

    logic [WIDTH-1:0] init_val, sh_step, alu_res, off_ext;
    shift_kind_t      init_kind;
    logic [4:0]       init_amt, k;
    logic [AW-1:0]    k_w;
    logic [3:0]       alu_fl;
    logic             unused_sr;

    assign unused_sr = ^{bus.sr_in[3:2], bus.sr_in[0]};

    // Val2 source selection; memory offsets take priority over immediates.
    always_comb begin
        init_val  = bus.val_rm;
        init_kind = shift_kind_t'(bus.shift_op[6:5]);
        init_amt  = bus.shift_op[11:7];
        if (bus.mem_read || bus.mem_write) begin
            init_val  = WIDTH'(bus.shift_op);
            init_kind = SH_LSL;
            init_amt  = '0;
        end else if (bus.imm) begin
            init_val  = WIDTH'(bus.shift_op[7:0]);
            init_kind = SH_ROR;
            init_amt  = {bus.shift_op[11:8], 1'b0};
        end else if (bus.shift_op[4]) begin
            init_kind = SH_LSL;
            init_amt  = '0;
        end
    end

    always_comb begin
        k       = (rem_q > STEP_AMT) ? STEP_AMT : rem_q;
        k_w     = AW'(k);
        sh_step = sh_q;
        case (kind_q)
            SH_LSL:  sh_step = sh_q << k;
            SH_LSR:  sh_step = sh_q >> k;
            SH_ASR:  sh_step = $signed(sh_q) >>> k;
            SH_ROR:  sh_step = (sh_q >> k) | (sh_q << (AW'(WIDTH) - k_w));
            default: sh_step = sh_q;
        endcase
    end

    assign off_ext = WIDTH'($signed(off_q));

    alu_flags #(.WIDTH(WIDTH)) u_alu (
        .a(rn_q), .b(sh_q), .cmd(cmd_q), .cin(cin_q), .result(alu_res), .flags(alu_fl)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            alu_result_q <= '0;
            br_q         <= '0;
            status_q     <= '0;
            sh_q         <= '0;
            kind_q       <= SH_LSL;
            rem_q        <= '0;
            rn_q         <= '0;
            pc_q         <= '0;
            off_q        <= '0;
            cmd_q        <= '0;
            cin_q        <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.in_valid) begin
                    sh_q       <= init_val;
                    kind_q     <= init_kind;
                    rem_q      <= init_amt;
                    rn_q       <= bus.val_rn;
                    pc_q       <= bus.pc;
                    off_q      <= bus.signed_imm_24;
                    cmd_q      <= bus.exe_cmd;
                    cin_q      <= bus.sr_in[1];
                    in_ready_q <= 1'b0;
                    state_q    <= (init_amt != '0) ? S_SHIFT : S_EXEC;
                end
                S_SHIFT: begin
                    sh_q  <= sh_step;
                    rem_q <= rem_q - k;
                    if (rem_q == k) state_q <= S_EXEC;
                end
                S_EXEC: begin
                    alu_result_q <= alu_res;
                    status_q     <= alu_fl;
                    br_q         <= pc_q + off_ext;
                    out_valid_q  <= 1'b1;
                    state_q      <= S_HOLD;
                end
                S_HOLD: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = alu_result_q;
    assign bus.br_address = br_q;
    assign bus.status     = status_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: identical stimulus to a STEP=1 and a STEP=4 instance.
module tb_exe_stage_mc;
    import exe_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 0, mem_read = 0, mem_write = 0, imm = 0, out_ready = 0;
    logic [3:0]  exe_cmd = 0, sr_in = 0;
    logic [31:0] pc = 0, val_rn = 0, val_rm = 0;
    logic [11:0] shift_op = 0;
    logic [23:0] signed_imm_24 = 0;

    exe_stage_mc_if #(.WIDTH(32)) if1 ();
    exe_stage_mc_if #(.WIDTH(32)) if4 ();

    assign if1.in_valid = in_valid;   assign if4.in_valid = in_valid;
    assign if1.mem_read = mem_read;   assign if4.mem_read = mem_read;
    assign if1.mem_write = mem_write; assign if4.mem_write = mem_write;
    assign if1.imm = imm;             assign if4.imm = imm;
    assign if1.exe_cmd = exe_cmd;     assign if4.exe_cmd = exe_cmd;
    assign if1.sr_in = sr_in;         assign if4.sr_in = sr_in;
    assign if1.pc = pc;               assign if4.pc = pc;
    assign if1.val_rn = val_rn;       assign if4.val_rn = val_rn;
    assign if1.val_rm = val_rm;       assign if4.val_rm = val_rm;
    assign if1.shift_op = shift_op;   assign if4.shift_op = shift_op;
    assign if1.signed_imm_24 = signed_imm_24; assign if4.signed_imm_24 = signed_imm_24;
    assign if1.out_ready = out_ready; assign if4.out_ready = out_ready;

    exe_stage_mc #(.WIDTH(32), .STEP(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    exe_stage_mc #(.WIDTH(32), .STEP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

    // scoreboard counters
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // driver: one full transaction on both instances, with backpressure and handshake
    task automatic run(input string tag, input logic mr, input logic im, input logic [3:0] cmd,
                       input logic [3:0] sr, input logic [31:0] p, input logic [31:0] rn,
                       input logic [31:0] rm, input logic [11:0] sop, input logic [23:0] off,
                       input int lat1_exp, input int lat4_exp, input logic [31:0] res_exp,
                       input logic [31:0] br_exp, input logic [3:0] st_exp);
        int lat1;
        int lat4;
        @(negedge clk);
        chk({tag, "/in_ready1"}, if1.in_ready, 1);
        chk({tag, "/in_ready4"}, if4.in_ready, 1);
        mem_read = mr; mem_write = 0; imm = im; exe_cmd = cmd; sr_in = sr;
        pc = p; val_rn = rn; val_rm = rm; shift_op = sop; signed_imm_24 = off;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        val_rn = $urandom_range(0, 32'hFFFF_FFFF); val_rm = $urandom_range(0, 32'hFFFF_FFFF);
        pc = $urandom_range(0, 32'hFFFF_FFFF); shift_op = 12'($urandom_range(0, 4095));
        exe_cmd = 4'($urandom_range(0, 15)); sr_in = 4'($urandom_range(0, 15));
        signed_imm_24 = 24'($urandom_range(0, 24'hFFFFFF)); imm = 1'($urandom_range(0, 1));
        lat1 = 0;
        lat4 = 0;
        for (int n = 1; n <= 40 && (lat1 == 0 || lat4 == 0); n++) begin
            @(posedge clk); #1;
            if (lat1 == 0 && if1.out_valid) lat1 = n;
            if (lat4 == 0 && if4.out_valid) lat4 = n;
            if (n == 1) begin
                chk({tag, "/busy_ready1"}, if1.in_ready, 0);
                chk({tag, "/busy_ready4"}, if4.in_ready, 0);
            end
        end
        chk({tag, "/lat1"}, lat1, lat1_exp);
        chk({tag, "/lat4"}, lat4, lat4_exp);
        chk({tag, "/res1"}, if1.alu_result, res_exp);
        chk({tag, "/res4"}, if4.alu_result, res_exp);
        chk({tag, "/st1"}, if1.status, st_exp);
        chk({tag, "/st4"}, if4.status, st_exp);
        chk({tag, "/br1"}, if1.br_address, br_exp);
        chk({tag, "/br4"}, if4.br_address, br_exp);
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, "/hold_res"}, if1.alu_result, res_exp);
        chk({tag, "/hold_valid"}, if1.out_valid, 1);
        chk({tag, "/hold_ready"}, if1.in_ready, 0);
        chk({tag, "/hold_state"}, if4.dbg_state, S_HOLD);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk({tag, "/done_valid1"}, if1.out_valid, 0);
        chk({tag, "/done_valid4"}, if4.out_valid, 0);
        chk({tag, "/done_state1"}, if1.dbg_state, S_IDLE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        // reset with in_valid asserted
        rst = 0; in_valid = 1; imm = 1; shift_op = 12'h1FF; exe_cmd = CMD_ADD; val_rn = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst/out_valid", if1.out_valid, 0);
        chk("rst/alu_result", if1.alu_result, 0);
        chk("rst/status", if1.status, 0);
        chk("rst/br", if4.br_address, 0);
        chk("rst/state", if1.dbg_state, S_IDLE);
        @(negedge clk);
        rst = 1; in_valid = 0;
        @(posedge clk); #1;
        chk("rst/in_ready1", if1.in_ready, 1);
        chk("rst/in_ready4", if4.in_ready, 1);

        //   tag     mr im cmd      sr     pc        rn            rm            sop     off        l1 l4 res           br        st
        run("imm",   0, 1, CMD_ADD, 4'h0, 32'h0,   32'h1,        32'h0,        12'h1FF, 24'h0,     3, 2, 32'hC000_0040, 32'h0,   4'b1000);
        run("ror4",  0, 0, CMD_MOV, 4'h0, 32'h0,   32'h0,        32'h0000_000F, 12'h260, 24'h0,    5, 2, 32'hF000_0000, 32'h0,   4'b1000);
        run("mem",   1, 0, CMD_ADD, 4'h0, 32'h100, 32'h100,      32'h0,        12'hFFF, 24'hFFFFFC, 1, 1, 32'h0000_10FF, 32'hFC,  4'b0000);
        run("ovf",   0, 0, CMD_SUB, 4'h0, 32'h0,   32'h8000_0000, 32'h1,       12'h000, 24'h0,     1, 1, 32'h7FFF_FFFF, 32'h0,   4'b0011);
        run("adc",   0, 0, CMD_ADC, 4'h2, 32'h40,  32'hFFFF_FFFF, 32'h0,       12'h000, 24'h000010, 1, 1, 32'h0,        32'h50,  4'b0110);
        run("asr",   0, 0, CMD_MOV, 4'h0, 32'h0,   32'h0,        32'h8000_0000, 12'h240, 24'h0,    5, 2, 32'hF800_0000, 32'h0,   4'b1000);
        run("sbc",   0, 0, CMD_SBC, 4'h0, 32'h0,   32'h5,        32'h5,        12'h000, 24'h0,     1, 1, 32'hFFFF_FFFF, 32'h0,   4'b1000);
        run("regsh", 0, 0, CMD_EOR, 4'h0, 32'h0,   32'hFF00_FF00, 32'h0F0F_0F0F, 12'h0F0, 24'h0,   1, 1, 32'hF00F_F00F, 32'h0,   4'b1000);
        run("undef", 0, 0, 4'hF,    4'h0, 32'h0,   32'h1,        32'h1,        12'h000, 24'h0,     1, 1, 32'h0,         32'h0,   4'b0000);
        run("lsr31", 0, 0, CMD_MOV, 4'h0, 32'h0,   32'h0,        32'h8000_0000, 12'hFA0, 24'h0,    32, 9, 32'h1,        32'h0,   4'b0000);
        run("imm30", 0, 1, CMD_MOV, 4'h0, 32'h0,   32'h0,        32'h0,        12'hF01, 24'h0,     31, 9, 32'h4,        32'h0,   4'b0000);
        run("and",   0, 0, CMD_AND, 4'h0, 32'h0,   32'h0000_F0F0, 32'h0000_FF00, 12'h000, 24'h0,   1, 1, 32'h0000_F000, 32'h0,   4'b0000);
        run("mvn",   0, 0, CMD_MVN, 4'h0, 32'h0,   32'h0,        32'h0,        12'h000, 24'h0,     1, 1, 32'hFFFF_FFFF, 32'h0,   4'b1000);

        // reset in the middle of a long shift
        @(negedge clk);
        mem_read = 0; imm = 0; exe_cmd = CMD_MOV; val_rm = 32'h1; shift_op = 12'hF80;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid/shifting", if1.dbg_state, S_SHIFT);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        chk("mid/state1", if1.dbg_state, S_IDLE);
        chk("mid/state4", if4.dbg_state, S_IDLE);
        chk("mid/ready1", if1.in_ready, 1);
        @(negedge clk);
        rst = 1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (if1.out_valid || if4.out_valid) seen = 1;
        end
        chk("mid/never_valid", seen, 0);
        chk("mid/res", if1.alu_result, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
